mem_req_arbiter: RTL

Arbitrates the three memory clients (instruction fetch, LSB load, LSB store) onto the single request port of `MemCtrl`, so each request is presented alone and held until done. Routes each completion back to its owner and inserts the idle gap `MemCtrl` needs between transactions. Drops speculative fetch and load traffic on rollback. Sits between ifetch/LSB and `MemCtrl` in the CPU top.

---
 rtl/mem_req_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_req_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings and widths for the memory request arbiter.
// States are fixed 3-bit codes so they can be compared against the rest of the CPU.
package mem_req_arbiter_pkg;

  localparam int ARB_STATE_WID = 3;
  localparam int ADDR_WID      = 32;
  localparam int DATA_WID      = 32;
  localparam int ST_LEN_WID    = 3;
  localparam int CACHE_BLK_SZ  = 64;

  typedef enum logic [ARB_STATE_WID-1:0] {
    ARB_IDLE    = 3'd0,
    ARB_BUSY_IF = 3'd1,
    ARB_BUSY_LD = 3'd2,
    ARB_BUSY_ST = 3'd3,
    ARB_GAP     = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic st;
    logic ld;
    logic fetch;
  } arb_grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select among fetch, load and store requesters.
// Produces a one-hot grant (or no grant when nothing may be accepted).
module mem_arb_pick
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             if_valid,
  input  logic             ld_valid,
  input  logic             st_valid,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic             rollback,
  output arb_grant_t       grant
);

  always_comb begin
    grant = '0;
    // A flush kills speculative traffic, so only a store may win during it.
    if (rollback) begin
      grant.st = st_valid;
    end else if (if_valid && (starve_cnt == CNT_W'(STARVE_MAX))) begin
      grant.fetch = 1'b1;
    end else if (st_valid) begin
      grant.st = 1'b1;
    end else if (ld_valid) begin
      grant.ld = 1'b1;
    end else if (if_valid) begin
      grant.fetch = 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises fetch/load/store requests onto the single MemCtrl request port,
// routes completions back to the owner and inserts one idle cycle between transactions.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int BLK_W      = 512,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,

  input  logic                  if_req_valid,
  input  logic [ADDR_WID-1:0]   if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [BLK_W-1:0]      if_resp_data,

  input  logic                  ld_req_valid,
  input  logic [ADDR_WID-1:0]   ld_req_addr,
  input  logic [ST_LEN_WID-1:0] ld_req_len,
  output logic                  ld_req_ready,
  output logic                  ld_resp_valid,
  output logic [DATA_WID-1:0]   ld_resp_data,

  input  logic                  st_req_valid,
  input  logic [ADDR_WID-1:0]   st_req_addr,
  input  logic [ST_LEN_WID-1:0] st_req_len,
  input  logic [DATA_WID-1:0]   st_req_data,
  output logic                  st_req_ready,
  output logic                  st_resp_valid,

  output logic                  mc_find_valid,
  output logic [ADDR_WID-1:0]   mc_find_addr,
  output logic                  mc_call_valid,
  output logic                  mc_call_is_store,
  output logic [ADDR_WID-1:0]   mc_call_addr,
  output logic [ST_LEN_WID-1:0] mc_call_len,
  output logic [DATA_WID-1:0]   mc_call_data,

  input  logic                  mc_data_valid,
  input  logic [BLK_W-1:0]      mc_data,
  input  logic                  mc_respond_valid,
  input  logic [DATA_WID-1:0]   mc_respond_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  arb_grant_t       grant;
  logic             pick_en;
  logic             acc_if;
  logic             acc_ld;
  logic             acc_st;
  logic             if_done;
  logic             ld_done;
  logic             st_done;

  function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_W'(STARVE_MAX)) return cnt;
    return cnt + CNT_W'(1);
  endfunction

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .if_valid   (if_req_valid),
    .ld_valid   (ld_req_valid),
    .st_valid   (st_req_valid),
    .starve_cnt (starve_cnt),
    .rollback   (rollback),
    .grant      (grant)
  );

  assign pick_en      = rdy && !rst && (state == ARB_IDLE);
  assign if_req_ready = pick_en && grant.fetch;
  assign ld_req_ready = pick_en && grant.ld;
  assign st_req_ready = pick_en && grant.st;

  assign acc_if = if_req_valid && if_req_ready;
  assign acc_ld = ld_req_valid && ld_req_ready;
  assign acc_st = st_req_valid && st_req_ready;

  // A completion racing a rollback on a speculative transaction is dropped.
  assign if_done = (state == ARB_BUSY_IF) && mc_data_valid && !rollback;
  assign ld_done = (state == ARB_BUSY_LD) && mc_respond_valid && !rollback;
  assign st_done = (state == ARB_BUSY_ST) && mc_respond_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (acc_st)      state_nxt = ARB_BUSY_ST;
        else if (acc_ld) state_nxt = ARB_BUSY_LD;
        else if (acc_if) state_nxt = ARB_BUSY_IF;
      end
      ARB_BUSY_IF: if (rollback || mc_data_valid)    state_nxt = ARB_GAP;
      ARB_BUSY_LD: if (rollback || mc_respond_valid) state_nxt = ARB_GAP;
      ARB_BUSY_ST: if (mc_respond_valid)             state_nxt = ARB_GAP;
      ARB_GAP:     state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      if (acc_if) begin
        starve_cnt <= '0;
      end else if ((acc_ld || acc_st) && if_req_valid) begin
        starve_cnt <= starve_inc(starve_cnt);
      end
    end
  end

  // Request side: valids are a registered decode of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_find_valid    <= 1'b0;
      mc_find_addr     <= '0;
      mc_call_valid    <= 1'b0;
      mc_call_is_store <= 1'b0;
      mc_call_addr     <= '0;
      mc_call_len      <= '0;
      mc_call_data     <= '0;
    end else if (rdy) begin
      mc_find_valid <= (state_nxt == ARB_BUSY_IF);
      mc_call_valid <= (state_nxt == ARB_BUSY_LD) || (state_nxt == ARB_BUSY_ST);
      if (acc_if) begin
        mc_find_addr <= if_req_addr;
      end
      if (acc_st) begin
        mc_call_is_store <= 1'b1;
        mc_call_addr     <= st_req_addr;
        mc_call_len      <= st_req_len;
        mc_call_data     <= st_req_data;
      end else if (acc_ld) begin
        mc_call_is_store <= 1'b0;
        mc_call_addr     <= ld_req_addr;
        mc_call_len      <= ld_req_len;
        mc_call_data     <= '0;
      end
    end
  end

  // Response side: one-cycle pulses that stretch while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
      st_resp_valid <= 1'b0;
    end else if (rdy) begin
      if_resp_valid <= if_done;
      ld_resp_valid <= ld_done;
      st_resp_valid <= st_done;
      if (if_done) if_resp_data <= mc_data;
      if (ld_done) ld_resp_data <= mc_respond_data;
    end
  end

endmodule
